// File: rtl/dut_pkt_pkg.sv
// -----------------------------------------------------------------------------
// dut_pkt_pkg
//   Shared definitions for the store-and-forward packet engine: CPU register
//   addresses, CTRL bit positions, the TX state encoding and the 9-bit FIFO
//   entry layout {last, data}.
// -----------------------------------------------------------------------------
package dut_pkt_pkg;

    // CPU register map
    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_RXCNT   = 8'h01;
    localparam logic [7:0] ADDR_TXCNT   = 8'h02;
    localparam logic [7:0] ADDR_DROPCNT = 8'h03;
    localparam logic [7:0] ADDR_STATUS  = 8'h04;
    localparam logic [7:0] ADDR_ID      = 8'h05;

    // CTRL bit indices and the mask of implemented CTRL bits
    localparam int         CTRL_TX_EN = 0;
    localparam int         CTRL_RX_EN = 1;
    localparam logic [7:0] CTRL_MASK  = 8'h03;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_GAP  = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic       last;   // final byte of a packet
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/pkt_sync_fifo.sv
// -----------------------------------------------------------------------------
// pkt_sync_fifo
//   Single-clock first-word-fall-through FIFO of fifo_entry_t entries.
//   Ports:
//     clk, rst_n   clock; asynchronous active-high reset (1 = reset)
//     push, wdata  write one entry (ignored when full)
//     pop          discard the head entry (ignored when empty)
//     rdata        current head entry (valid while !empty)
//     full, empty  occupancy flags
//     free_cnt     number of free entries (0..DEPTH)
// -----------------------------------------------------------------------------
module pkt_sync_fifo
    import dut_pkt_pkg::*;
#(
    parameter int DEPTH = 64        // power of 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  fifo_entry_t               wdata,
    input  logic                      pop,
    output fifo_entry_t               rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array is deliberately not reset; pointers and count
    // alone decide which entries are valid, so clearing them empties the FIFO.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata    = mem[rd_ptr];
    assign full     = (count == DEPTH_V);
    assign empty    = (count == '0);
    assign free_cnt = DEPTH_V - count;

endmodule

// File: rtl/dut_pkt_engine.sv
// -----------------------------------------------------------------------------
// dut_pkt_engine
//   Store-and-forward byte-packet engine. Whole packets received on
//   rxd/rx_vld are buffered in a FIFO and replayed unchanged on txd/tx_vld.
//   A CPU register port exposes control, counters, status and a device ID.
//   Ports:
//     clk            single clock, posedge
//     rst_n          asynchronous reset, active-high (1 = reset)
//     addr/rw/din    CPU access: rw=1 writes din to addr at the clock edge
//     dout           registered read data (1-cycle latency, held while rw=1)
//     rxd/rx_vld     receive byte stream; packet = run of rx_vld=1 cycles
//     txd/tx_vld     transmit byte stream; packet = run of tx_vld=1 cycles
// -----------------------------------------------------------------------------
module dut_pkt_engine
    import dut_pkt_pkg::*;
#(
    parameter int         FIFO_DEPTH = 64,
    parameter int         MAX_PKT    = 16,
    parameter logic [7:0] DEV_ID     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic       rw,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] rxd,
    input  logic       rx_vld,
    output logic [7:0] txd,
    output logic       tx_vld
);

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int BCW = $clog2(MAX_PKT + 1);
    localparam logic [FAW:0]   MAX_PKT_F = (FAW + 1)'(MAX_PKT);
    localparam logic [BCW-1:0] MAX_PKT_B = BCW'(MAX_PKT);
    localparam logic [FAW:0]   SAT_LIMIT = (FAW + 1)'(15);

    // Registers
    logic [7:0]  ctrl;
    logic [7:0]  rx_cnt;
    logic [7:0]  tx_cnt;
    logic [7:0]  drop_cnt;
    logic [FAW:0] pkt_count;     // committed packets in FIFO (up to FIFO_DEPTH)

    // RX path
    logic           rx_vld_q;
    logic           rx_acc;      // current packet was admitted
    logic [BCW-1:0] byte_cnt;    // bytes kept so far in current packet
    logic [7:0]     pend_data;   // last kept byte, pushed once its 'last' flag is known
    logic           pkt_start;
    logic           pkt_end;
    logic           admit;
    logic           take;
    logic           commit;
    logic           drop_inc;
    logic [BCW-1:0] cnt_eff;

    // FIFO interface
    logic           fifo_push;
    fifo_entry_t    fifo_wdata;
    logic           fifo_pop;
    fifo_entry_t    fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FAW:0]   fifo_free;

    // TX path
    tx_state_e state_q;
    tx_state_e state_d;
    logic      tx_done;

    // CPU
    logic [7:0] rd_data;
    logic [3:0] pkt_sat;

    // ---------------------------------------------------------------- RX ---
    // Each kept byte is parked in pend_data and pushed when the next kept byte
    // arrives; the commit cycle pushes the parked byte with last=1, which also
    // covers 1-byte packets.
    assign pkt_start = rx_vld && !rx_vld_q;
    assign pkt_end   = !rx_vld && rx_vld_q;
    assign admit     = ctrl[CTRL_RX_EN] && (fifo_free >= MAX_PKT_F);
    assign cnt_eff   = pkt_start ? '0 : byte_cnt;
    assign take      = rx_vld && (pkt_start ? admit : rx_acc) && (cnt_eff < MAX_PKT_B);
    assign commit    = pkt_end && rx_acc;
    assign drop_inc  = pkt_start && !admit && ctrl[CTRL_RX_EN];

    assign fifo_push       = commit || (take && (cnt_eff != '0));
    assign fifo_wdata.last = commit;
    assign fifo_wdata.data = pend_data;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_vld_q  <= 1'b0;
            rx_acc    <= 1'b0;
            byte_cnt  <= '0;
            pend_data <= '0;
        end else begin
            rx_vld_q <= rx_vld;
            if (pkt_start)    rx_acc <= admit;
            else if (pkt_end) rx_acc <= 1'b0;
            if (take) begin
                pend_data <= rxd;
                byte_cnt  <= cnt_eff + 1'b1;
            end
        end
    end

    pkt_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .wdata    (fifo_wdata),
        .pop      (fifo_pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free_cnt (fifo_free)
    );

    // ---------------------------------------------------------------- TX ---
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_q <= TX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: if (ctrl[CTRL_TX_EN] && (pkt_count != '0)) state_d = TX_SEND;
            TX_SEND: if (tx_done) state_d = TX_GAP;
            TX_GAP:  state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        fifo_pop = 1'b0;
        tx_done  = 1'b0;
        if (state_q == TX_SEND && !fifo_empty) begin
            fifo_pop = 1'b1;
            tx_done  = fifo_rdata.last;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tx_vld <= 1'b0;
            txd    <= '0;
        end else begin
            tx_vld <= fifo_pop;
            txd    <= fifo_pop ? fifo_rdata.data : 8'h00;
        end
    end

    // --------------------------------------------------- registers / CPU ---
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ctrl      <= '0;
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            drop_cnt  <= '0;
            pkt_count <= '0;
        end else begin
            if (rw && addr == ADDR_CTRL) ctrl <= din & CTRL_MASK;

            // A CPU clear in the same cycle as an increment wins.
            if (rw && addr == ADDR_RXCNT)        rx_cnt <= '0;
            else if (commit)                     rx_cnt <= rx_cnt + 1'b1;
            if (rw && addr == ADDR_TXCNT)        tx_cnt <= '0;
            else if (tx_done)                    tx_cnt <= tx_cnt + 1'b1;
            if (rw && addr == ADDR_DROPCNT)      drop_cnt <= '0;
            else if (drop_inc)                   drop_cnt <= drop_cnt + 1'b1;

            // Commit and completion in the same cycle cancel out.
            case ({commit, tx_done})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    assign pkt_sat = (pkt_count > SAT_LIMIT) ? 4'hF : pkt_count[3:0];

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            ADDR_CTRL:    rd_data = ctrl;
            ADDR_RXCNT:   rd_data = rx_cnt;
            ADDR_TXCNT:   rd_data = tx_cnt;
            ADDR_DROPCNT: rd_data = drop_cnt;
            ADDR_STATUS:  rd_data = {pkt_sat, 1'b0, (state_q != TX_IDLE), fifo_full, fifo_empty};
            ADDR_ID:      rd_data = DEV_ID;
            default:      rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)    dout <= '0;
        else if (!rw) dout <= rd_data;
    end

endmodule

// File: tb/tb_dut_pkt_engine.sv
// -----------------------------------------------------------------------------
// tb_dut_pkt_engine
//   Self-checking bench for dut_pkt_engine. A packet-level reference model
//   (queues of expected bytes and packet lengths, plus expected counters)
//   predicts the transmitted stream; a monitor collects tx bursts.
// -----------------------------------------------------------------------------
module tb_dut_pkt_engine;
    import dut_pkt_pkg::*;

    localparam int MAX_PKT = 16;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] addr   = 8'h00;
    logic       rw     = 1'b0;
    logic [7:0] din    = 8'h00;
    logic [7:0] rxd    = 8'h00;
    logic       rx_vld = 1'b0;
    logic [7:0] dout;
    logic [7:0] txd;
    logic       tx_vld;

    int tests_run    = 0;
    int tests_failed = 0;

    // Stimulus and reference model
    logic [7:0] stim[$];
    logic [7:0] exp_bytes[$];
    int         exp_lens[$];
    int         exp_rx   = 0;
    int         exp_tx   = 0;
    int         exp_drop = 0;

    // Monitor state
    logic [7:0] tx_bytes[$];
    int         tx_lens[$];
    int         cur_len    = 0;
    int         idle_run   = 0;
    int         min_gap    = 1000;
    bit         seen_burst = 1'b0;

    logic [7:0] v;

    dut_pkt_engine #(
        .FIFO_DEPTH (64),
        .MAX_PKT    (MAX_PKT),
        .DEV_ID     (8'hA5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .rw     (rw),
        .din    (din),
        .dout   (dout),
        .rxd    (rxd),
        .rx_vld (rx_vld),
        .txd    (txd),
        .tx_vld (tx_vld)
    );

    always #5 clk = ~clk;

    // Collect tx bursts on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (tx_vld) begin
            if (cur_len == 0 && seen_burst && idle_run < min_gap) min_gap = idle_run;
            idle_run = 0;
            cur_len++;
            tx_bytes.push_back(txd);
        end else begin
            if (cur_len != 0) begin
                tx_lens.push_back(cur_len);
                cur_len    = 0;
                seen_burst = 1'b1;
            end
            idle_run++;
        end
    end

    // ------------------------------------------------------------ helpers ---
    task automatic clear_mon();
        tx_bytes.delete();
        tx_lens.delete();
        cur_len    = 0;
        idle_run   = 0;
        min_gap    = 1000;
        seen_burst = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        addr = a; din = d; rw = 1'b1;
        @(posedge clk); #1;
        rw = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        addr = a; rw = 1'b0;
        @(posedge clk); #1;
        d = dout;
    endtask

    task automatic make_stim(input int len);
        stim.delete();
        for (int i = 0; i < len; i++) stim.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_stim();
        foreach (stim[i]) begin
            @(posedge clk); #1;
            rxd = stim[i]; rx_vld = 1'b1;
        end
        @(posedge clk); #1;
        rx_vld = 1'b0; rxd = 8'h00;
    endtask

    // Model: an admitted packet is forwarded truncated to MAX_PKT bytes.
    task automatic model_accept();
        int n;
        n = (stim.size() > MAX_PKT) ? MAX_PKT : stim.size();
        for (int i = 0; i < n; i++) exp_bytes.push_back(stim[i]);
        exp_lens.push_back(n);
        exp_rx++;
    endtask

    task automatic clear_counters();
        cpu_write(ADDR_RXCNT, 8'h5A);
        cpu_write(ADDR_TXCNT, 8'hFF);
        cpu_write(ADDR_DROPCNT, 8'h03);
        exp_rx = 0; exp_tx = 0; exp_drop = 0;
    endtask

    task automatic wait_bursts(input int n, input int budget, input string name);
        int cyc = 0;
        while (tx_lens.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        repeat (6) @(negedge clk);
        tests_run++;
        if (tx_lens.size() !== n) begin
            tests_failed++;
            $display("FAIL %s_burst_count: got %0d bursts, expected %0d", name, tx_lens.size(), n);
        end
    endtask

    task automatic compare_bursts(input int n, input string name);
        for (int p = 0; p < n; p++) begin
            int         el;
            int         al;
            int         bad;
            logic [7:0] e;
            logic [7:0] a;
            el  = -1;
            al  = -1;
            bad = -1;
            if (exp_lens.size() > 0) el = exp_lens.pop_front();
            if (tx_lens.size() > 0)  al = tx_lens.pop_front();
            for (int i = 0; i < el || i < al; i++) begin
                e = 8'h00;
                a = 8'h00;
                if (i < el && exp_bytes.size() > 0) e = exp_bytes.pop_front();
                if (i < al && tx_bytes.size() > 0)  a = tx_bytes.pop_front();
                if (bad < 0 && (i >= el || i >= al || a !== e)) bad = i;
            end
            tests_run++;
            if (al !== el || bad >= 0) begin
                tests_failed++;
                $display("FAIL %s_pkt%0d: got len %0d, expected len %0d, first bad byte at %0d",
                         name, p, al, el, bad);
            end
        end
        exp_tx += n;
    endtask

    // -------------------------------------------------------------- tests ---
    task automatic test_reset();
        logic [7:0] exp_reset [5];
        exp_reset = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        cpu_read(ADDR_ID, v);
        tests_run++;
        if (v !== 8'hA5) begin tests_failed++; $display("FAIL reset_id: got %h expected %h", v, 8'hA5); end
        for (int a = 0; a < 5; a++) begin
            cpu_read(8'(a), v);
            tests_run++;
            if (v !== exp_reset[a]) begin
                tests_failed++;
                $display("FAIL reset_reg%0d: got %h expected %h", a, v, exp_reset[a]);
            end
        end
        cpu_read(8'h06, v);
        tests_run++;
        if (v !== 8'h00) begin tests_failed++; $display("FAIL unmapped_read: got %h expected 00", v); end
        cpu_write(ADDR_CTRL, 8'hFC);
        cpu_read(ADDR_CTRL, v);
        tests_run++;
        if (v !== 8'h00) begin tests_failed++; $display("FAIL ctrl_mask: got %h expected 00", v); end
        repeat (10) @(negedge clk);
        tests_run++;
        if ((tx_lens.size() + cur_len) !== 0) begin
            tests_failed++;
            $display("FAIL reset_tx_quiet: got %0d tx activity, expected 0", tx_lens.size() + cur_len);
        end
    endtask

    task automatic test_forward();
        cpu_write(ADDR_CTRL, 8'h03);
        stim = '{8'h11, 8'h22, 8'h33, 8'h44};
        model_accept();
        send_stim();
        wait_bursts(1, 100, "forward");
        compare_bursts(1, "forward");
        cpu_read(ADDR_RXCNT, v);
        tests_run++;
        if (v !== 8'(exp_rx)) begin tests_failed++; $display("FAIL forward_rxcnt: got %h expected %h", v, 8'(exp_rx)); end
        cpu_read(ADDR_TXCNT, v);
        tests_run++;
        if (v !== 8'(exp_tx)) begin tests_failed++; $display("FAIL forward_txcnt: got %h expected %h", v, 8'(exp_tx)); end
    endtask

    task automatic test_truncate();
        clear_counters();
        clear_mon();
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(8'(i));
        model_accept();
        send_stim();
        wait_bursts(1, 100, "truncate");
        compare_bursts(1, "truncate");
        cpu_read(ADDR_RXCNT, v);
        tests_run++;
        if (v !== 8'(exp_rx)) begin tests_failed++; $display("FAIL truncate_rxcnt: got %h expected %h", v, 8'(exp_rx)); end
        cpu_read(ADDR_DROPCNT, v);
        tests_run++;
        if (v !== 8'(exp_drop)) begin tests_failed++; $display("FAIL truncate_dropcnt: got %h expected %h", v, 8'(exp_drop)); end
    endtask

    task automatic test_hold_release();
        int lens [3];
        lens = '{1, $urandom_range(2, 16), $urandom_range(17, 24)};
        clear_counters();
        clear_mon();
        cpu_write(ADDR_CTRL, 8'h02);
        for (int p = 0; p < 3; p++) begin
            make_stim(lens[p]);
            model_accept();
            send_stim();
            repeat (2) @(posedge clk);
        end
        repeat (20) @(posedge clk);
        cpu_read(ADDR_STATUS, v);
        tests_run++;
        if (v !== 8'h30) begin tests_failed++; $display("FAIL hold_status: got %h expected %h", v, 8'h30); end
        tests_run++;
        if ((tx_lens.size() + cur_len) !== 0) begin
            tests_failed++;
            $display("FAIL hold_no_tx: got %0d tx activity, expected 0", tx_lens.size() + cur_len);
        end
        cpu_write(ADDR_CTRL, 8'h03);
        wait_bursts(3, 300, "release");
        compare_bursts(3, "release");
        tests_run++;
        if (min_gap < 1) begin tests_failed++; $display("FAIL release_gap: got %0d idle cycles, expected >= 1", min_gap); end
        cpu_read(ADDR_TXCNT, v);
        tests_run++;
        if (v !== 8'(exp_tx)) begin tests_failed++; $display("FAIL release_txcnt: got %h expected %h", v, 8'(exp_tx)); end
        cpu_read(ADDR_STATUS, v);
        tests_run++;
        if (v !== 8'h01) begin tests_failed++; $display("FAIL release_status: got %h expected 01", v); end
    endtask

    task automatic test_overflow();
        clear_counters();
        clear_mon();
        cpu_write(ADDR_CTRL, 8'h02);
        for (int p = 0; p < 4; p++) begin
            make_stim(MAX_PKT);
            model_accept();
            send_stim();
            repeat (2) @(posedge clk);
        end
        cpu_read(ADDR_STATUS, v);
        tests_run++;
        if (v !== 8'h42) begin tests_failed++; $display("FAIL overflow_status: got %h expected 42", v); end
        make_stim(MAX_PKT);
        exp_drop++;                      // no room for a full-size packet
        send_stim();
        repeat (2) @(posedge clk);
        cpu_read(ADDR_DROPCNT, v);
        tests_run++;
        if (v !== 8'(exp_drop)) begin tests_failed++; $display("FAIL overflow_dropcnt: got %h expected %h", v, 8'(exp_drop)); end
        cpu_read(ADDR_RXCNT, v);
        tests_run++;
        if (v !== 8'(exp_rx)) begin tests_failed++; $display("FAIL overflow_rxcnt: got %h expected %h", v, 8'(exp_rx)); end
        cpu_write(ADDR_DROPCNT, 8'h03);
        exp_drop = 0;
        cpu_read(ADDR_DROPCNT, v);
        tests_run++;
        if (v !== 8'(exp_drop)) begin tests_failed++; $display("FAIL drop_clear: got %h expected %h", v, 8'(exp_drop)); end
        // With RX disabled a refused packet is not counted as a drop.
        cpu_write(ADDR_CTRL, 8'h00);
        make_stim(5);
        send_stim();
        repeat (2) @(posedge clk);
        cpu_read(ADDR_DROPCNT, v);
        tests_run++;
        if (v !== 8'(exp_drop)) begin tests_failed++; $display("FAIL rx_dis_dropcnt: got %h expected %h", v, 8'(exp_drop)); end
        cpu_write(ADDR_CTRL, 8'h03);
        wait_bursts(4, 400, "overflow");
        compare_bursts(4, "overflow");
        cpu_read(ADDR_TXCNT, v);
        tests_run++;
        if (v !== 8'(exp_tx)) begin tests_failed++; $display("FAIL overflow_txcnt: got %h expected %h", v, 8'(exp_tx)); end
    endtask

    task automatic test_random();
        clear_counters();
        clear_mon();
        cpu_write(ADDR_CTRL, 8'h03);
        for (int p = 0; p < 20; p++) begin
            make_stim($urandom_range(1, 24));
            model_accept();
            send_stim();
            repeat ($urandom_range(3, 6)) @(posedge clk);
        end
        wait_bursts(20, 2000, "random");
        compare_bursts(20, "random");
        cpu_read(ADDR_RXCNT, v);
        tests_run++;
        if (v !== 8'(exp_rx)) begin tests_failed++; $display("FAIL random_rxcnt: got %h expected %h", v, 8'(exp_rx)); end
        cpu_read(ADDR_TXCNT, v);
        tests_run++;
        if (v !== 8'(exp_tx)) begin tests_failed++; $display("FAIL random_txcnt: got %h expected %h", v, 8'(exp_tx)); end
        cpu_read(ADDR_DROPCNT, v);
        tests_run++;
        if (v !== 8'(exp_drop)) begin tests_failed++; $display("FAIL random_dropcnt: got %h expected %h", v, 8'(exp_drop)); end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        logic [7:0] exp_after [5];
        exp_after = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        cpu_write(ADDR_CTRL, 8'h03);
        make_stim(MAX_PKT);
        send_stim();
        cyc = 0;
        while (tx_vld !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (tx_vld !== 1'b1) begin tests_failed++; $display("FAIL midrst_burst_start: got tx_vld %b expected 1", tx_vld); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (tx_vld !== 1'b0) begin tests_failed++; $display("FAIL midrst_tx_vld: got %b expected 0", tx_vld); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        for (int a = 0; a < 5; a++) begin
            cpu_read(8'(a), v);
            tests_run++;
            if (v !== exp_after[a]) begin
                tests_failed++;
                $display("FAIL midrst_reg%0d: got %h expected %h", a, v, exp_after[a]);
            end
        end
        clear_mon();
        exp_bytes.delete();
        exp_lens.delete();
        repeat (20) @(negedge clk);
        tests_run++;
        if ((tx_lens.size() + cur_len) !== 0) begin
            tests_failed++;
            $display("FAIL midrst_quiet: got %0d tx activity, expected 0", tx_lens.size() + cur_len);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_truncate();
        test_hold_release();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
